// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and helpers for the instruction-fetch buffer.
//   addr_t / instr_t  : 16-bit fetch address and instruction
//   fetch_entry_t     : instruction-queue entry {instr, pc}
//   INSTR_BYTES       : PC step per fetched instruction
//   sat_add32         : saturating 32-bit add for the optional perf counters
package ifetch_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [15:0] instr_t;

    typedef struct packed {
        instr_t instr;
        addr_t  pc;
    } fetch_entry_t;

    localparam int INSTR_BYTES = 2;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous FIFO, DEPTH entries (power of 2) of WIDTH bits.
//   clk, reset  : clock, asynchronous active-high reset
//   push_i      : write data_i at the tail (caller guarantees not full)
//   pop_i       : drop the head (caller guarantees not empty)
//   clear_i     : empty the FIFO; overrides push/pop
//   data_o      : head entry (registered storage, no bypass)
//   count_o     : occupancy 0..DEPTH
module ifetch_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q, count_d;

    assign count_d = count_q + CW'(push_i) - CW'(pop_i);

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: turns the PC's fetch address into in-order memory reads and
// queues returned instructions for decode. Credit based: fetches in flight,
// queued instructions and responses still to be discarded never exceed DEPTH.
//   clk, reset          : clock, asynchronous active-high reset
//   pc_addr_i / pc_en_o : PC value in, PC load enable out (request or flush)
//   mem_req_o/mem_addr_o: read request (always accepted), address = pc_addr_i
//   mem_rvalid_i/rdata_i: in-order read responses
//   flush_i             : redirect, discards queued and in-flight fetches
//   dec_valid_o/instr_o/pc_o, dec_ready_i : decode handshake on the queue head
// Optional (macro IFETCH_PERF_EN): stall_cycles_o, flushed_instrs_o counters.
module ifetch_buffer
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  addr_t  pc_addr_i,
    output logic   pc_en_o,
    output logic   mem_req_o,
    output addr_t  mem_addr_o,
    input  logic   mem_rvalid_i,
    input  instr_t mem_rdata_i,
    input  logic   flush_i,
    output logic   dec_valid_o,
    output instr_t dec_instr_o,
    output addr_t  dec_pc_o,
    input  logic   dec_ready_i
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flushed_instrs_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] out_cnt;    // in-flight fetches == address-queue occupancy
    logic [CW-1:0] iq_cnt;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW+1:0] credits_used;
    logic          rsp_accept, rsp_drop, rsp_any, iq_pop;
    addr_t         head_addr;
    fetch_entry_t  push_ent, head_ent;

    assign credits_used = {2'b00, out_cnt} + {2'b00, iq_cnt} + {2'b00, drop_q};

    // Gated by reset so the PC is frozen while the block is held in reset.
    assign mem_req_o  = !reset && !flush_i && (credits_used < (CW+2)'(DEPTH));
    assign pc_en_o    = !reset && (mem_req_o || flush_i);
    assign mem_addr_o = pc_addr_i;

    // A response with nothing outstanding and nothing to drop is ignored.
    assign rsp_drop   = mem_rvalid_i && (drop_q != '0);
    assign rsp_accept = mem_rvalid_i && (drop_q == '0) && (out_cnt != '0);
    assign rsp_any    = mem_rvalid_i && ((drop_q != '0) || (out_cnt != '0));
    assign iq_pop     = dec_valid_o && dec_ready_i;

    // On flush every outstanding fetch becomes a drop, less the response
    // that lands in the flush cycle itself.
    always_comb begin
        drop_d = drop_q;
        if (flush_i)       drop_d = drop_q + out_cnt - CW'(rsp_any);
        else if (rsp_drop) drop_d = drop_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_q <= '0;
        else       drop_q <= drop_d;
    end

    ifetch_fifo #(.WIDTH($bits(addr_t)), .DEPTH(DEPTH)) u_addr_q (
        .clk     (clk),
        .reset   (reset),
        .push_i  (mem_req_o),
        .pop_i   (rsp_accept),
        .clear_i (flush_i),
        .data_i  (pc_addr_i),
        .data_o  (head_addr),
        .count_o (out_cnt)
    );

    assign push_ent = '{instr: mem_rdata_i, pc: head_addr};

    ifetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_q (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rsp_accept),
        .pop_i   (iq_pop),
        .clear_i (flush_i),
        .data_i  (push_ent),
        .data_o  (head_ent),
        .count_o (iq_cnt)
    );

    assign dec_valid_o = (iq_cnt != '0);
    assign dec_instr_o = head_ent.instr;
    assign dec_pc_o    = head_ent.pc;

`ifdef IFETCH_PERF_EN
    logic [31:0] stall_q, flushed_q, flushed_inc;

    // Entries cleared by a flush exclude the one decode takes that cycle.
    always_comb begin
        flushed_inc = '0;
        if (flush_i)       flushed_inc = 32'(iq_cnt) - 32'(iq_pop) + 32'(rsp_any);
        else if (rsp_drop) flushed_inc = 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q   <= '0;
            flushed_q <= '0;
        end else begin
            if (!mem_req_o && !flush_i) stall_q <= sat_add32(stall_q, 32'd1);
            flushed_q <= sat_add32(flushed_q, flushed_inc);
        end
    end

    assign stall_cycles_o   = stall_q;
    assign flushed_instrs_o = flushed_q;
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference model and an in-order memory.
module tb_ifetch_buffer;
    import ifetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_addr;
    logic        pc_en, mem_req;
    logic [15:0] mem_addr;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        flush;
    logic        dec_valid;
    logic [15:0] dec_instr, dec_pc;
    logic        dec_ready;
`ifdef IFETCH_PERF_EN
    logic [31:0] stall_cycles, flushed_instrs;
`endif

    always #5 clk = ~clk;

    ifetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_addr_i    (pc_addr),
        .pc_en_o      (pc_en),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .flush_i      (flush),
        .dec_valid_o  (dec_valid),
        .dec_instr_o  (dec_instr),
        .dec_pc_o     (dec_pc),
        .dec_ready_i  (dec_ready)
`ifdef IFETCH_PERF_EN
        ,
        .stall_cycles_o   (stall_cycles),
        .flushed_instrs_o (flushed_instrs)
`endif
    );

    typedef struct { logic [15:0] instr; logic [15:0] pc; } ent_t;
    typedef struct { logic [15:0] data; int due; } rsp_t;

    int tests = 0, fails = 0;
    logic [15:0] inflight[$];   // addresses awaiting a response
    ent_t        iq[$];         // what decode should see
    int          drop = 0;      // responses still to be discarded
    rsp_t        memq[$];       // memory: pending responses, in order
    int          cyc = 0, lat = 1, jit = 0, dut_req = 0;
    logic [15:0] target = 16'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Entered and left at posedge+1.
    task automatic step();
        logic rv, exp_req;
        logic [15:0] rd;
        ent_t e;
        rv = (memq.size() > 0) && (memq[0].due <= cyc);
        rd = rv ? memq[0].data : 16'($urandom);
        mem_rvalid = rv;
        mem_rdata  = rd;
        #2;
        exp_req = !flush && ((inflight.size() + iq.size() + drop) < DEPTH);
        chk("mem_req", mem_req, exp_req);
        chk("pc_en", pc_en, exp_req | flush);
        chk("mem_addr", mem_addr, pc_addr);
        if (mem_req) dut_req++;
        @(posedge clk);
        #1;
        if (rv) void'(memq.pop_front());
        if (exp_req)
            memq.push_back('{data: 16'($urandom), due: cyc + lat + int'($urandom_range(0, jit))});
        if (flush) begin
            drop += inflight.size();
            if (rv && drop > 0) drop--;
            iq.delete();
            inflight.delete();
            pc_addr = target;
        end else begin
            if (dec_ready && iq.size() > 0) void'(iq.pop_front());
            if (rv) begin
                if (drop > 0) drop--;
                else if (inflight.size() > 0) begin
                    e.instr = rd;
                    e.pc    = inflight.pop_front();
                    iq.push_back(e);
                end
            end
            if (exp_req) begin
                inflight.push_back(pc_addr);
                pc_addr = pc_addr + 16'(INSTR_BYTES);
            end
        end
        cyc++;
        chk("dec_valid", dec_valid, iq.size() > 0);
        if (iq.size() > 0) begin
            chk("dec_instr", dec_instr, iq[0].instr);
            chk("dec_pc", dec_pc, iq[0].pc);
        end
    endtask

    // Asserts reset away from any clock edge and checks outputs respond at once.
    task automatic do_reset();
        #2;
        reset      = 1'b1;
        mem_rvalid = 1'b0;
        flush      = 1'b0;
        #1;
        chk("rst_dec_valid", dec_valid, 1'b0);
        chk("rst_dec_instr", dec_instr, 16'h0);
        chk("rst_dec_pc", dec_pc, 16'h0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_pc_en", pc_en, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        inflight.delete();
        iq.delete();
        memq.delete();
        drop    = 0;
        pc_addr = 16'h0;
    endtask

    initial begin
        reset = 1'b1; pc_addr = 16'h0; mem_rvalid = 1'b0; mem_rdata = 16'h0;
        flush = 1'b0; dec_ready = 1'b1;

        // Streaming: L=1, decode always ready
        do_reset();
        lat = 1; jit = 0; dec_ready = 1'b1;
        repeat (12) step();

        // Back-pressure: exactly DEPTH requests, then one credit per pop
        do_reset();
        dec_ready = 1'b0; dut_req = 0;
        repeat (8) step();
        chk("full_req_cnt", dut_req, DEPTH);
        dec_ready = 1'b1; step();
        dec_ready = 1'b0; step(); step();
        chk("credit_req_cnt", dut_req, DEPTH + 1);

        // Flush with two fetches outstanding at L=3, redirect to 0x0100
        do_reset();
        lat = 3; dec_ready = 1'b1;
        step(); step();
        flush = 1'b1; target = 16'h0100; step();
        flush = 1'b0;
        chk("flush_dec_valid", dec_valid, 1'b0);
        repeat (10) step();

        // Flush coinciding with the only outstanding response
        do_reset();
        lat = 1;
        step();
        flush = 1'b1; target = 16'h0200; step();
        flush = 1'b0;
        repeat (6) step();

        // Flush coinciding with a decode handshake
        do_reset();
        dec_ready = 1'b1;
        repeat (5) step();
        flush = 1'b1; target = 16'h0300; step();
        flush = 1'b0;
        repeat (5) step();

        // Reset mid-stream with three instructions queued
        do_reset();
        dec_ready = 1'b0;
        repeat (4) step();
        chk("pre_rst_qlen", iq.size(), 3);
        do_reset();
        dec_ready = 1'b1;
        repeat (8) step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                lat = int'($urandom_range(1, 4));
                jit = int'($urandom_range(0, 2));
            end
            if (i % 1000 == 999) do_reset();
            dec_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            target    = 16'($urandom) & 16'hFFFE;
            step();
        end
        flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
